// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for a 5-stage pipeline with memory-wait timeout and perf counters
module pipeline_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
  state_t state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic load_use, freeze, brf, luf;
  // hazard detection; a frozen pipe overrides branch, and a branch squashes the wrong-path load-use
  always_comb begin
    load_use = ex_mem_read & (ex_rd != '0) &
               ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    freeze   = (state == HALT) | (~mem_ready & ((state == MEM_WAIT) | mem_req));
    brf      = ~reset & ~freeze & branch_taken;
    luf      = ~reset & ~freeze & ~branch_taken & load_use;
  end
  // Mealy enable/flush outputs, reset forces every stage to a NOP
  always_comb begin
    pc_en       = ~reset & ~freeze & ~luf;
    ifid_en     = ~reset & ~freeze & ~luf;
    ifid_flush  = reset | brf;
    idex_en     = ~reset & ~freeze;
    idex_flush  = reset | brf | luf;
    exmem_en    = ~reset & ~freeze;
    memwb_flush = reset | freeze;
    halted      = ~reset & (state == HALT);
  end
  // next state: first non-ready cycle counts as wait 1, the MAX_WAIT-th one halts
  always_comb begin
    state_nxt = RUN;
    wait_nxt  = '0;
    if (state == HALT) begin
      state_nxt = HALT;
      wait_nxt  = wait_cnt;
    end else if (freeze) begin
      state_nxt = (state == MEM_WAIT && wait_cnt == WW'(MAX_WAIT - 1)) ? HALT : MEM_WAIT;
      wait_nxt  = (state == RUN) ? WW'(1) : wait_cnt + WW'(1);
    end
  end
  // state, sticky timeout and saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      mem_timeout <= mem_timeout | (state_nxt == HALT);
      if (state != HALT && !pc_en && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (brf && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard-driven scenario checks of the hazard controller
module tb_pipeline_hazard_ctrl;
  localparam logic [8:0] C_DEF  = 9'b110101000;
  localparam logic [8:0] C_RST  = 9'b001010100;
  localparam logic [8:0] C_RSTT = 9'b001010101;
  localparam logic [8:0] C_LU   = 9'b000111000;
  localparam logic [8:0] C_BR   = 9'b111111000;
  localparam logic [8:0] C_FRZ  = 9'b000000100;
  localparam logic [8:0] C_HLT  = 9'b000000111;
  localparam logic [6:0] IDLE = 7'b0000000, RST = 7'b1000000, RSTJ = 7'b1100010;
  localparam logic [6:0] LU = 7'b0100000, LUX0 = 7'b0110000, LUR2 = 7'b0101000;
  localparam logic [6:0] BRLU = 7'b0100100, BR = 7'b0000100, MW = 7'b0000010;
  localparam logic [6:0] MR = 7'b0000011, MRBR = 7'b0000111, MWBR = 7'b0000110;
  logic clk = 0, reset = 1;
  logic [4:0] id_rs1 = 5, id_rs2 = 9, ex_rd = 0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, branch_taken = 0, mem_req = 0, mem_ready = 0;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, halted, mem_timeout;
  logic [2:0] stall_cnt, flush_cnt;
  logic [14:0] obs, exp_v;
  logic [14:0] sb[$];
  int checks = 0, passed = 0;
  pipeline_hazard_ctrl #(.REG_W(5), .MAX_WAIT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_flush(memwb_flush),
    .halted(halted), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
  always #5 clk = ~clk;
  assign obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, halted,
                mem_timeout, stall_cnt, flush_cnt};
  task automatic step(input logic [6:0] s, input logic [14:0] e);
    @(posedge clk);
    #1;
    reset        = s[6];
    ex_mem_read  = s[5];
    ex_rd        = s[4] ? 5'd0 : (s[3] ? 5'd9 : 5'd5);
    id_use_rs1   = ~s[3];
    id_use_rs2   = s[3];
    branch_taken = s[2];
    mem_req      = s[1];
    mem_ready    = s[0];
    sb.push_back(e);
    @(negedge clk);
  endtask
  task automatic test_reset;
    logic [6:0] s[2] = '{RSTJ, IDLE};
    logic [14:0] e[2] = '{{C_RST, 3'd0, 3'd0}, {C_DEF, 3'd0, 3'd0}};
    for (int i = 0; i < 2; i++) begin
      step(s[i], e[i]);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL reset[%0d]: got %b want %b", i, obs, exp_v);
      else passed++;
    end
  endtask
  task automatic test_load_use;
    logic [6:0] s[4] = '{LU, IDLE, LUR2, IDLE};
    logic [14:0] e[4] = '{{C_LU, 3'd0, 3'd0}, {C_DEF, 3'd1, 3'd0}, {C_LU, 3'd1, 3'd0}, {C_DEF, 3'd2, 3'd0}};
    for (int i = 0; i < 4; i++) begin
      step(s[i], e[i]);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL load_use[%0d]: got %b want %b", i, obs, exp_v);
      else passed++;
    end
  endtask
  task automatic test_x0;
    logic [6:0] s[2] = '{LUX0, IDLE};
    logic [14:0] e[2] = '{{C_DEF, 3'd2, 3'd0}, {C_DEF, 3'd2, 3'd0}};
    for (int i = 0; i < 2; i++) begin
      step(s[i], e[i]);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL x0[%0d]: got %b want %b", i, obs, exp_v);
      else passed++;
    end
  endtask
  task automatic test_branch;
    logic [6:0] s[2] = '{BRLU, IDLE};
    logic [14:0] e[2] = '{{C_BR, 3'd2, 3'd0}, {C_DEF, 3'd2, 3'd1}};
    for (int i = 0; i < 2; i++) begin
      step(s[i], e[i]);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL branch[%0d]: got %b want %b", i, obs, exp_v);
      else passed++;
    end
  endtask
  task automatic test_memwait;
    logic [6:0] s[9] = '{MW, MW, MW, MR, LU, IDLE, MW, MRBR, IDLE};
    logic [14:0] e[9] = '{{C_FRZ, 3'd2, 3'd1}, {C_FRZ, 3'd3, 3'd1}, {C_FRZ, 3'd4, 3'd1},
                          {C_DEF, 3'd5, 3'd1}, {C_LU, 3'd5, 3'd1}, {C_DEF, 3'd6, 3'd1},
                          {C_FRZ, 3'd6, 3'd1}, {C_BR, 3'd7, 3'd1}, {C_DEF, 3'd7, 3'd2}};
    for (int i = 0; i < 9; i++) begin
      step(s[i], e[i]);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL memwait[%0d]: got %b want %b", i, obs, exp_v);
      else passed++;
    end
  endtask
  task automatic test_saturation;
    for (int i = 0; i < 22; i++) begin
      if (i == 0) step(RST, {C_RST, 3'd7, 3'd2});
      else if (i <= 10) step(LU, {C_LU, (i > 8) ? 3'd7 : 3'(i - 1), 3'd0});
      else if (i <= 19) step(BR, {C_BR, 3'd7, (i > 18) ? 3'd7 : 3'(i - 11)});
      else if (i == 20) step(RSTJ, {C_RST, 3'd7, 3'd7});
      else step(IDLE, {C_DEF, 3'd0, 3'd0});
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL saturation[%0d]: got %b want %b", i, obs, exp_v);
      else passed++;
    end
  endtask
  task automatic test_timeout;
    logic [6:0] s[8] = '{MW, MW, MW, MW, MR, BRLU, RST, IDLE};
    logic [14:0] e[8] = '{{C_FRZ, 3'd0, 3'd0}, {C_FRZ, 3'd1, 3'd0}, {C_FRZ, 3'd2, 3'd0},
                          {C_FRZ, 3'd3, 3'd0}, {C_HLT, 3'd4, 3'd0}, {C_HLT, 3'd4, 3'd0},
                          {C_RSTT, 3'd4, 3'd0}, {C_DEF, 3'd0, 3'd0}};
    for (int i = 0; i < 8; i++) begin
      step(s[i], e[i]);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL timeout[%0d]: got %b want %b", i, obs, exp_v);
      else passed++;
    end
  endtask
  task automatic test_back_to_back;
    logic [6:0] s[7] = '{LU, LU, MWBR, MR, MW, RST, IDLE};
    logic [14:0] e[7] = '{{C_LU, 3'd0, 3'd0}, {C_LU, 3'd1, 3'd0}, {C_FRZ, 3'd2, 3'd0},
                          {C_DEF, 3'd3, 3'd0}, {C_FRZ, 3'd3, 3'd0}, {C_RST, 3'd4, 3'd0},
                          {C_DEF, 3'd0, 3'd0}};
    for (int i = 0; i < 7; i++) begin
      step(s[i], e[i]);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL back_to_back[%0d]: got %b want %b", i, obs, exp_v);
      else passed++;
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    test_reset;
    test_load_use;
    test_x0;
    test_branch;
    test_memwait;
    test_saturation;
    test_timeout;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). It drives the enable and flush inputs of the PC and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves load-use hazards, taken-branch flushes and data-memory wait states, and halts the core on a memory timeout. It also keeps saturating stall and flush performance counters.

Parameters:
REG_W, 5, register index width.
MAX_WAIT, 16, max consecutive data-memory wait cycles before halt (>=2).
CNT_W, 16, performance counter width.

Ports:
clk  in  1  clock; all state on rising edge.
reset  in  1  synchronous, active-high reset.
id_rs1  in  REG_W  rs1 of instruction in ID.
id_rs2  in  REG_W  rs2 of instruction in ID.
id_use_rs1  in  1  ID instruction reads rs1.
id_use_rs2  in  1  ID instruction reads rs2.
ex_rd  in  REG_W  destination of instruction in EX.
ex_mem_read  in  1  EX instruction is a load.
branch_taken  in  1  EX resolved a taken branch/jump this cycle.
mem_req  in  1  MEM stage accesses data memory this cycle.
mem_ready  in  1  data memory completes the access this cycle.
pc_en  out  1  PC update enable.
ifid_en  out  1  IF/ID load enable.
ifid_flush  out  1  IF/ID clear to NOP (wins over ifid_en).
idex_en  out  1  ID/EX load enable.
idex_flush  out  1  ID/EX clear to NOP.
exmem_en  out  1  EX/MEM load enable.
memwb_flush  out  1  MEM/WB load NOP (no writeback).
halted  out  1  controller in HALT.
mem_timeout  out  1  sticky timeout error.
stall_cnt  out  CNT_W  cycles with pc_en=0 outside HALT/reset.
flush_cnt  out  CNT_W  taken-branch flush events.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- While reset=1: all *_en=0, ifid_flush=idex_flush=memwb_flush=1, halted=0. On that edge: state<=RUN, wait_cnt<=0, mem_timeout<=0, both counters<=0. Reset mid-MEM_WAIT or mid-HALT behaves identically.
- All enable/flush outputs are combinational (Mealy) from state and current inputs. Counters and state are registered.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- memwait = mem_req & ~mem_ready.
- Default outputs: all *_en=1, all flushes=0.
- State RUN, priority memwait > branch_taken > load_use:
  - memwait: pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1. wait_cnt<=1; next MEM_WAIT.
  - branch_taken: defaults, plus ifid_flush=idex_flush=1 (2-cycle penalty). flush_cnt++. A simultaneous load_use is ignored because ID holds a wrong-path instruction.
  - load_use: pc_en=ifid_en=0, idex_flush=1, producing exactly one bubble; the load is in MEM next cycle, so no state is needed.
- State MEM_WAIT:
  - mem_ready=0: freeze as above; wait_cnt++. If wait_cnt==MAX_WAIT-1, next HALT and mem_timeout<=1.
  - mem_ready=1: evaluate the RUN rules (branch/load_use apply; the memwait term is false). Next RUN; wait_cnt<=0.
- State HALT: freeze as above (all enables 0, memwb_flush=1), halted=1, mem_timeout held at 1. The only exit is reset. No counter updates.
- stall_cnt increments on every non-reset, non-HALT cycle with pc_en=0.
- Both counters saturate at 2^CNT_W-1 (no wrap).
- Timing: the freeze is zero-latency, effective the same cycle the condition is seen. Timeout is declared after MAX_WAIT consecutive non-ready cycles.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> that cycle pc_en=0, ifid_en=0, idex_flush=1. Next cycle (ex_mem_read=0) all enables=1. stall_cnt=1.
- x0 exemption: same as load-use but ex_rd=0 -> no stall, stall_cnt stays 0.
- Branch beats load-use: branch_taken=1 with a load_use condition active -> pc_en=1, ifid_flush=idex_flush=1, flush_cnt=1, stall_cnt=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> 3 frozen cycles with memwb_flush=1. Release cycle has defaults. State back to RUN, stall_cnt=3.
- Timeout: MAX_WAIT=4, mem_req=1, mem_ready held 0 -> after 4 frozen cycles halted=1, mem_timeout=1. Raising mem_ready keeps HALT. reset clears halted, mem_timeout and the counters.
- Saturation: CNT_W=3, 10 load-use stalls -> stall_cnt=7. Reset asserted mid-sequence -> outputs take reset values the same cycle.
